// File: rtl/dsp_inverse_div_if.sv
// Bundles the operand, request and result signals of dsp_inverse_div.
// master: the requester. It drives start, P, C, D and B, and it samples the results.
// slave : the divider. It samples the operands and drives busy, done and the result fields.
interface dsp_inverse_div_if;
    logic        start;
    logic [47:0] P;
    logic [47:0] C;
    logic [17:0] D;
    logic [17:0] B;
    logic        busy;
    logic        done;
    logic [47:0] quo;
    logic [17:0] rem;
    logic [17:0] A_out;
    logic        overflow;
    logic        div_by_zero;

    modport master (
        output start, P, C, D, B,
        input  busy, done, quo, rem, A_out, overflow, div_by_zero
    );

    modport slave (
        input  start, P, C, D, B,
        output busy, done, quo, rem, A_out, overflow, div_by_zero
    );
endinterface

// File: rtl/dsp_inverse_div.sv
// dsp_inverse_div: recovers the multiplier operand A of the pre-add/multiply/post-add
// DSP slice. It uses a restoring divider that produces one quotient bit per clock.
//   ADD      : A = (P - C) / (D + B)
//   SUBTRACT : A = (P + C) / (D - B)
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - dsp_inverse_div_if.slave. It carries start, P, C, D and B in,
//          and busy, done, quo, rem, A_out, overflow and div_by_zero out.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands are captured on the accepting edge
// DIV   | one restoring-division step per clock, 48 steps, N MSB first
// FIN   | publish the result registers; done is asserted on the next cycle
module dsp_inverse_div #(
    parameter string OPERATION = "ADD"
) (
    input  logic              clk,
    input  logic              rst,
    dsp_inverse_div_if.slave  bus
);

    localparam bit SUB_MODE = (OPERATION == "SUBTRACT");

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [17:0] s_q, s_d;          // captured divisor
    logic [47:0] n_q, n_d;          // dividend; shifts left as bits are consumed
    logic [17:0] r_q, r_d;          // partial remainder, always < divisor
    logic [47:0] q_q, q_d;          // quotient being assembled
    logic [5:0]  cnt_q, cnt_d;
    logic        dbz_q, dbz_d;      // divide-by-zero seen at capture
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [47:0] quo_q, quo_d;
    logic [17:0] rem_q, rem_d;
    logic        ovf_q, ovf_d;
    logic        dbz_out_q, dbz_out_d;

    logic [17:0] s_in;
    logic [47:0] n_in;
    logic [18:0] r_shift;

    // The arithmetic wraps modulo the operand width, the same way the forward slice does.
    always_comb begin
        if (SUB_MODE) begin
            s_in = bus.D - bus.B;
            n_in = bus.P + bus.C;
        end else begin
            s_in = bus.D + bus.B;
            n_in = bus.P - bus.C;
        end
    end

    // The working remainder is one bit wider than the divisor.
    // It holds the shifted-in bit before the trial subtraction.
    assign r_shift = {r_q, n_q[47]};

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        r_d       = r_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        dbz_d     = dbz_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        quo_d     = quo_q;
        rem_d     = rem_q;
        ovf_d     = ovf_q;
        dbz_out_d = dbz_out_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    s_d    = s_in;
                    n_d    = n_in;
                    r_d    = '0;
                    q_d    = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (s_in == 18'd0) begin
                        dbz_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = ST_DIV;
                    end
                end
            end

            ST_DIV: begin
                n_d = {n_q[46:0], 1'b0};
                if (r_shift >= {1'b0, s_q}) begin
                    r_d = 18'(r_shift - {1'b0, s_q});
                    q_d = {q_q[46:0], 1'b1};
                end else begin
                    r_d = r_shift[17:0];
                    q_d = {q_q[46:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd47) begin
                    state_d = ST_FIN;
                end
            end

            ST_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (dbz_q) begin
                    quo_d     = '1;
                    rem_d     = '0;
                    ovf_d     = 1'b1;
                    dbz_out_d = 1'b1;
                end else begin
                    quo_d     = q_q;
                    rem_d     = r_q;
                    ovf_d     = |q_q[47:18];
                    dbz_out_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            s_q       <= '0;
            n_q       <= '0;
            r_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            ovf_q     <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            r_q       <= r_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            dbz_q     <= dbz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            ovf_q     <= ovf_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quo         = quo_q;
    assign bus.rem         = rem_q;
    assign bus.A_out       = quo_q[17:0];
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_out_q;

endmodule

// File: doc/dsp_inverse_div.md
Name: dsp_inverse_div

Overview:
Sequential restoring divider that inverts the team's pre-adder/multiply/post-add DSP slice. Given a DSP result P and the same C, D, B operands, it recovers the multiplier operand A:
- ADD mode: A = (P - C) / (D + B)
- SUBTRACT mode: A = (P + C) / (D - B)

It sits downstream of the DSP slice in the check/readback path and uses one quotient bit per clock with a start/busy/done handshake.

Parameters:
OPERATION, "ADD", selects the inverse formula; legal values "ADD" and "SUBTRACT"; must match the forward DSP configuration.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
start  input  1  request; sampled only when busy=0.
P  input  48  DSP result to invert.
C  input  48  post-adder operand.
D  input  18  pre-adder operand.
B  input  18  pre-adder operand.
busy  output  1  high from the cycle after start is accepted until done is asserted.
done  output  1  one-cycle pulse; result outputs are valid from this cycle.
quo  output  48  full unsigned quotient.
rem  output  18  unsigned remainder.
A_out  output  18  quo[17:0], the recovered A.
overflow  output  1  quo[47:18] != 0, so the quotient does not fit A's width.
div_by_zero  output  1  divisor was zero.

Behaviour:
- Reset: synchronous, active-high, overrides everything. All outputs go to 0 and the state machine returns to IDLE.
  - Reset mid-operation aborts silently: no done pulse, and results from the aborted run are never presented.
- Arithmetic, modulo operand width, matching the forward slice:
  - ADD: S = (D+B) mod 2^18; N = (P-C) mod 2^48.
  - SUBTRACT: S = (D-B) mod 2^18; N = (P+C) mod 2^48.
  - All values are unsigned.
- States: IDLE, DIV, FIN.
- IDLE:
  - start=1 captures S and N from the current inputs into internal registers; busy=1 next cycle.
  - If S != 0: go to DIV with iteration counter = 0 and partial remainder = 0 (19-bit working width).
  - If S == 0: go directly to FIN with the div_by_zero condition latched.
  - Input changes after the capture edge have no effect.
- DIV, one iteration per clock, processing N from MSB to LSB:
  - r' = {r[17:0], next N bit}.
  - If r' >= S: r = r' - S and shift quotient bit 1; else r = r' and shift 0.
  - After 48 iterations (counter reaches 47), go to FIN.
- FIN, one cycle:
  - Register quo, rem, A_out, overflow and div_by_zero.
  - Assert done=1 and busy=0 in the following cycle, then return to IDLE.
- Latency:
  - Start accepted at edge k: done is high in the cycle after edge k+49.
  - Divide-by-zero: done is high in the cycle after edge k+1.
- Divide-by-zero results: quo = 48'hFFFF_FFFF_FFFF, rem = 0, overflow = 1, div_by_zero = 1.
- Result hold: quo, rem, A_out, overflow and div_by_zero hold until the next FIN cycle. They are not cleared by a new start; they are cleared only by rst.
- Handshake edge cases:
  - start while busy=1 is ignored, with no queuing.
  - start=1 held continuously restarts in the cycle after done, since IDLE samples start on that cycle.
  - start coincident with rst: reset wins.
- done is never high for more than one consecutive cycle.

Test Plan:
- ADD, P=150, C=100, D=7, B=3 (S=10, N=50), start pulse -> busy for 49 cycles, then done pulse with quo=5, A_out=5, rem=0, overflow=0, div_by_zero=0.
- SUBTRACT, P=8, C=20, D=10, B=3 (S=7, N=28) -> quo=4, rem=0. Then P=103, C=0, D=10, B=0 in ADD -> quo=10, rem=3.
- ADD, P=2^40, C=0, D=1, B=0 -> quo=2^40, A_out=0, overflow=1. Also ADD with D=2^18-1, B=1 (S wraps to 0) -> done 2 cycles after start, div_by_zero=1, quo all ones, rem=0.
- SUBTRACT, D=5, B=5 -> div_by_zero=1. Then ADD with P=5, C=10 (N wraps to 2^48-5), D=1, B=0 -> quo=2^48-5, overflow=1.
- Start accepted; pulse start again at cycles 10 and 30 with different operands -> single done at cycle 49 carrying the first operands' result. Then hold start high -> back-to-back results, done pulses 50 cycles apart.
- Assert rst at cycle 20 of a division -> next cycle busy=0 and all outputs 0, no done. A fresh start afterwards -> correct result with normal latency.
